// File: rtl/mult_table_ctrl_if.sv
// Request/response, status and AXI4-Lite master signals of the multiplication-table controller.
// Valid/ready: a transfer occurs on a rising clk edge where valid and ready are both high; once valid
// is raised, it and its payload stay unchanged until that edge.
interface mult_table_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  a;
  logic [2:0]  b;
  logic        rsp_valid;
  logic [5:0]  result;
  logic        rsp_err;
  logic        init_done;
  logic        error;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  // master: the controller; slave: the requester together with the AXI4-Lite memory
  modport master (
    input  req_valid, a, b,
    output req_ready, rsp_valid, result, rsp_err, init_done, error,
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );

  modport slave (
    output req_valid, a, b,
    input  req_ready, rsp_valid, result, rsp_err, init_done, error,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/mult_table_ctrl.sv
// Fills a 64-entry a*b table in AXI4-Lite memory after reset, then answers (a,b) lookups by
// reading the table back one transaction at a time.
module mult_table_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  mult_table_ctrl_if.master  bus,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    W_ADDR = 3'd0,
    W_RESP = 3'd1,
    IDLE   = 3'd2,
    R_ADDR = 3'd3,
    R_DATA = 3'd4
  } state_t;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_run;
  logic [5:0]        r_idx;
  logic              r_aw_done;
  logic              r_w_done;
  logic [2:0]        r_a;
  logic [2:0]        r_b;
  logic [WAIT_W-1:0] r_wait;
  logic              r_init_done;
  logic              r_error;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [5:0]        r_result;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_wr_go;
  logic              w_b_done;
  logic              w_req_hs;
  logic              w_ar_hs;
  logic              w_r_done;
  logic              w_timeout;
  logic [5:0]        w_wr_prod;
  logic [31:0]       w_wr_addr;
  logic [31:0]       w_rd_addr;
  logic              w_unused;

  assign w_wr_prod = {3'b000, r_idx[5:3]} * {3'b000, r_idx[2:0]};
  assign w_wr_addr = ADDR_BASE + {24'b0, r_idx, 2'b00};
  assign w_rd_addr = ADDR_BASE + {24'b0, r_a, r_b, 2'b00};
  assign w_timeout = (r_wait == WAIT_MAX);
  assign w_unused  = ^bus.m_axi_rdata[31:6];

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.result    = r_result;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.init_done = r_init_done;
  assign bus.error     = r_error;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= W_ADDR;
    else     r_state <= w_state_nxt;
  end

  // r_run keeps the write channel quiet for the first cycle after reset.
  always_comb begin
    w_state_nxt       = r_state;
    bus.req_ready     = 1'b0;
    bus.m_axi_awaddr  = 32'h0;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wdata   = 32'h0;
    bus.m_axi_wstrb   = 4'h0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_bready  = 1'b0;
    bus.m_axi_araddr  = 32'h0;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_rready  = 1'b0;
    w_aw_hs           = 1'b0;
    w_w_hs            = 1'b0;
    w_wr_go           = 1'b0;
    w_b_done          = 1'b0;
    w_req_hs          = 1'b0;
    w_ar_hs           = 1'b0;
    w_r_done          = 1'b0;
    case (r_state)
      W_ADDR: begin
        if (r_run) begin
          bus.m_axi_awaddr  = w_wr_addr;
          bus.m_axi_awvalid = !r_aw_done;
          bus.m_axi_wdata   = {26'b0, w_wr_prod};
          bus.m_axi_wstrb   = 4'hF;
          bus.m_axi_wvalid  = !r_w_done;
          w_aw_hs           = !r_aw_done && bus.m_axi_awready;
          w_w_hs            = !r_w_done && bus.m_axi_wready;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            w_wr_go     = 1'b1;
            w_state_nxt = W_RESP;
          end
        end
      end
      W_RESP: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid || w_timeout) begin
          w_b_done    = 1'b1;
          w_state_nxt = (r_idx == 6'd63) ? IDLE : W_ADDR;
        end
      end
      IDLE: begin
        bus.req_ready = r_init_done;
        if (r_init_done && bus.req_valid) begin
          w_req_hs    = 1'b1;
          w_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        bus.m_axi_arvalid = 1'b1;
        bus.m_axi_araddr  = w_rd_addr;
        if (bus.m_axi_arready) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        bus.m_axi_rready = 1'b1;
        if (bus.m_axi_rvalid || w_timeout) begin
          w_r_done    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = W_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_idx       <= 6'd0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_a         <= 3'd0;
      r_b         <= 3'd0;
      r_wait      <= '0;
      r_init_done <= 1'b0;
      r_error     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_result    <= 6'd0;
    end else begin
      r_run       <= 1'b1;
      r_rsp_valid <= 1'b0;
      if (w_wr_go) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      // The wait counter restarts on each entry to a response-waiting state.
      if (w_wr_go || w_ar_hs)
        r_wait <= '0;
      else if ((r_state == W_RESP || r_state == R_DATA) && !w_timeout)
        r_wait <= r_wait + 1'b1;
      if (w_b_done) begin
        if (!bus.m_axi_bvalid || bus.m_axi_bresp != 2'b00) r_error <= 1'b1;
        if (r_idx == 6'd63) r_init_done <= 1'b1;
        else                r_idx       <= r_idx + 6'd1;
      end
      if (w_req_hs) begin
        r_a <= bus.a;
        r_b <= bus.b;
      end
      if (w_r_done) begin
        r_rsp_valid <= 1'b1;
        if (bus.m_axi_rvalid) begin
          r_result  <= bus.m_axi_rdata[5:0];
          r_rsp_err <= (bus.m_axi_rresp != 2'b00);
          if (bus.m_axi_rresp != 2'b00) r_error <= 1'b1;
        end else begin
          r_result  <= 6'd0;
          r_rsp_err <= 1'b1;
          r_error   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_table_ctrl.sv
// Directed bench for mult_table_ctrl: table initialisation, lookups, error/timeout paths and
// mid-transaction reset, against an AXI4-Lite memory model driven on the falling edge.
module tb_mult_table_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         cyc = 0;

  mult_table_ctrl_if bus();

  mult_table_ctrl #(.ADDR_BASE(32'h0), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave model knobs and scoreboard
  int          aw_delay = 0, w_delay = 0, bad_b_idx = 99, wr_cnt = 0;
  bit          check_holds = 0, r_bad = 0, r_withhold = 0;
  int          aw_hold = 0, w_hold = 0, aw_len = 0, w_len = 0;
  int          aw_unstable = 0, w_unstable = 0, bad_strb = 0, overlap = 0;
  logic [31:0] aw_first, w_first, got_aw, got_w, ar_cap;
  logic [5:0]  mem [64];
  logic [63:0] exp_q[$];

  task automatic load_exp();
    exp_q.delete();
    for (int i = 0; i < 64; i++)
      exp_q.push_back({32'(i * 4), 32'((i >> 3) * (i & 7))});
  endtask

  task automatic commit_write();
    logic [63:0] exp;
    exp = {64{1'b1}};
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    check_eq("wr_addr_data", {got_aw, got_w}, exp);
    if (check_holds) begin
      check_eq("aw_hold_len", 64'(aw_len), 64'd4);
      check_eq("w_hold_len", 64'(w_len), 64'd1);
    end
    mem[got_aw[7:2]] = got_w[5:0];
    wr_cnt++;
  endtask

  initial begin
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = 32'h0;
    bus.m_axi_rresp   = 2'b00;
    for (int i = 0; i < 64; i++) mem[i] = 6'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        aw_hold = 0;
        w_hold  = 0;
      end else begin
        if (bus.m_axi_awvalid) begin
          aw_hold++;
          if (aw_hold == 1) aw_first = bus.m_axi_awaddr;
          else if (bus.m_axi_awaddr !== aw_first) aw_unstable++;
          bus.m_axi_awready = (aw_hold > aw_delay);
          if (bus.m_axi_awready) begin
            got_aw = bus.m_axi_awaddr;
            aw_len = aw_hold;
          end
        end else begin
          bus.m_axi_awready = 1'b0;
          aw_hold = 0;
        end
        if (bus.m_axi_wvalid) begin
          w_hold++;
          if (bus.m_axi_wstrb !== 4'hF) bad_strb++;
          if (w_hold == 1) w_first = bus.m_axi_wdata;
          else if (bus.m_axi_wdata !== w_first) w_unstable++;
          bus.m_axi_wready = (w_hold > w_delay);
          if (bus.m_axi_wready) begin
            got_w = bus.m_axi_wdata;
            w_len = w_hold;
          end
        end else begin
          bus.m_axi_wready = 1'b0;
          w_hold = 0;
        end
        bus.m_axi_bvalid = bus.m_axi_bready;
        bus.m_axi_bresp  = (wr_cnt == bad_b_idx) ? 2'b10 : 2'b00;
        if (bus.m_axi_bvalid) commit_write();
        bus.m_axi_arready = bus.m_axi_arvalid;
        if (bus.m_axi_arvalid) ar_cap = bus.m_axi_araddr;
        if (bus.m_axi_rready && !r_withhold) begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rdata  = {26'h2AAAAAA, mem[ar_cap[7:2]]};
          bus.m_axi_rresp  = r_bad ? 2'b10 : 2'b00;
        end else begin
          bus.m_axi_rvalid = 1'b0;
          bus.m_axi_rdata  = 32'hFFFF_FFFF;
          bus.m_axi_rresp  = 2'b00;
        end
        if ((bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_bready) &&
            (bus.m_axi_arvalid || bus.m_axi_rready)) overlap++;
      end
    end
  end

  task automatic wait_init(input string tag);
    int guard = 0, early_rdy = 0, early_ar = 0;
    while (!bus.init_done && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (bus.req_ready && !bus.init_done) early_rdy++;
      if (bus.m_axi_arvalid) early_ar++;
    end
    check_eq({tag, "_done"}, 64'(bus.init_done), 64'd1);
    check_eq({tag, "_writes"}, 64'(wr_cnt), 64'd64);
    check_eq({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    check_eq({tag, "_ready_early"}, 64'(early_rdy), 64'd0);
    check_eq({tag, "_ar_early"}, 64'(early_ar), 64'd0);
  endtask

  // mode 0: exact N+3 latency; mode 1: read timeout window
  task automatic do_request(input string tag, input logic [2:0] ra, input logic [2:0] rb,
                            input logic [5:0] exp_res, input logic exp_err, input int mode);
    int  n_acc, lat, guard;
    bit  got;
    bus.a = ra;
    bus.b = rb;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_accept"}, 64'(bus.req_ready), 64'd1);
    n_acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.a = ~ra;
    bus.b = ~rb;
    check_eq({tag, "_arvalid"}, 64'(bus.m_axi_arvalid), 64'd1);
    check_eq({tag, "_araddr"}, 64'(bus.m_axi_araddr), 64'({24'b0, ra, rb, 2'b00}));
    got = 0;
    guard = 0;
    while (!got && guard < 400) begin
      if (bus.rsp_valid) got = 1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    check_eq({tag, "_rsp_seen"}, 64'(got), 64'd1);
    lat = cyc - n_acc;
    if (mode == 0) check_eq({tag, "_latency"}, 64'(lat), 64'd3);
    else           check_eq({tag, "_to_latency"}, 64'(lat >= 257 && lat <= 259), 64'd1);
    check_eq({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    check_eq({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
    @(negedge clk);
    check_eq({tag, "_pulse_hold"}, 64'({bus.rsp_valid, bus.result, bus.rsp_err}),
             64'({1'b0, exp_res, exp_err}));
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.a = 3'd7;
    bus.b = 3'd6;
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
             bus.m_axi_arvalid, bus.m_axi_rready, bus.req_ready, bus.rsp_valid, bus.rsp_err,
             bus.init_done, bus.error, bus.m_axi_wstrb}), 64'd0);
    check_eq("rst_addr", {bus.m_axi_awaddr, bus.m_axi_araddr}, 64'd0);
    check_eq("rst_data", 64'({bus.m_axi_wdata, bus.result}), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    load_exp();
    rst = 1'b0;

    // req_valid stays high through initialisation
    wait_init("init1");
    check_eq("init1_error", 64'(bus.error), 64'd0);
    do_request("rd76", 3'd7, 3'd6, 6'd42, 1'b0, 0);
    do_request("rd25", 3'd2, 3'd5, 6'd10, 1'b0, 0);
    do_request("rd00", 3'd0, 3'd0, 6'd0, 1'b0, 0);
    do_request("rd77", 3'd7, 3'd7, 6'd49, 1'b0, 0);
    check_eq("good_reads_error", 64'(bus.error), 64'd0);

    r_bad = 1;
    do_request("rd33_bad", 3'd3, 3'd3, 6'd9, 1'b1, 0);
    r_bad = 0;
    check_eq("bad_read_error", 64'(bus.error), 64'd1);
    do_request("rd14", 3'd1, 3'd4, 6'd4, 1'b0, 0);
    check_eq("error_sticky", 64'(bus.error), 64'd1);

    r_withhold = 1;
    do_request("rd55_to", 3'd5, 3'd5, 6'd0, 1'b1, 1);

    // reset in the middle of a read that never completes
    bus.a = 3'd4;
    bus.b = 3'd4;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_rready", 64'(bus.m_axi_rready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ar_r", 64'({bus.m_axi_arvalid, bus.m_axi_rready}), 64'd0);
    check_eq("mid_rst_status", 64'({bus.error, bus.init_done}), 64'd0);
    check_eq("mid_rst_state", 64'(dbg_state), 64'd0);
    wr_cnt      = 0;
    aw_delay    = 3;
    check_holds = 1;
    bad_b_idx   = 10;
    r_withhold  = 0;
    load_exp();
    @(negedge clk);
    rst = 1'b0;

    wait_init("init2");
    check_eq("init2_bresp_error", 64'(bus.error), 64'd1);
    do_request("rd63", 3'd6, 3'd3, 6'd18, 1'b0, 0);

    check_eq("aw_stable", 64'(aw_unstable), 64'd0);
    check_eq("w_stable", 64'(w_unstable), 64'd0);
    check_eq("wstrb_full", 64'(bad_strb), 64'd0);
    check_eq("chan_overlap", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
